// File: rtl/st_packet_channel_arbiter_pkg.sv
// Shared types and helpers for the packet channel arbiter.
// State encoding, default widths and index-width helper.
package st_packet_channel_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CHANNEL_W = 8;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/st_packet_channel_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches from last_grant+1, wrapping modulo NUM_IN.
module rr_arbiter
  import st_packet_channel_arbiter_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = idx_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_req
);

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      j = int'(last_grant) + 1 + i;
      if (j >= NUM_IN) j = j - NUM_IN;
      jj = IDX_W'(j);
      if (!any_req && req[jj]) begin
        any_req   = 1'b1;
        grant_idx = jj;
      end
    end
  end

endmodule

// File: rtl/st_packet_channel_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_IN
// Avalon-ST byte streams into one channel-tagged stream.
module st_packet_channel_arbiter
  import st_packet_channel_arbiter_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CHANNEL_W = DEF_CHANNEL_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic                     busy,
  output logic                     sop_err
);

  localparam int IDX_W = idx_width(NUM_IN);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             any_req;
  logic             load_en;
  logic             accept;
  logic             first_beat;
  logic [DATA_W-1:0] sel_data;
  logic             sel_sop;
  logic             sel_eop;

  assign load_en  = out_ready | ~out_valid;
  assign sel_data = in_data[grant*DATA_W +: DATA_W];
  assign sel_sop  = in_startofpacket[grant];
  assign sel_eop  = in_endofpacket[grant];
  assign accept   = (state == BUSY) & in_valid[grant] & load_en;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .grant_idx  (arb_idx),
    .any_req    (any_req)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = BUSY;
      BUSY:    if (accept && sel_eop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    busy     = (state == BUSY);
    if (state == BUSY) in_ready[grant] = load_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= IDX_W'(NUM_IN - 1);
      first_beat <= 1'b0;
    end else if (state == IDLE && any_req) begin
      grant      <= arb_idx;
      last_grant <= arb_idx;
      first_beat <= 1'b1;
    end else if (accept) begin
      first_beat <= 1'b0;
    end
  end

  // sop_err flags a missing sop on the first beat or a stray sop later
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
      sop_err           <= 1'b0;
    end else begin
      sop_err <= 1'b0;
      if (load_en) begin
        out_valid <= accept;
        if (accept) begin
          out_data          <= sel_data;
          out_startofpacket <= sel_sop;
          out_endofpacket   <= sel_eop;
          out_channel       <= CHANNEL_W'(grant);
        end
      end
      if (accept) sop_err <= first_beat ? ~sel_sop : sel_sop;
    end
  end

endmodule

// File: tb/tb_st_packet_channel_arbiter.sv
// Bench for st_packet_channel_arbiter: queue-driven requesters,
// packet-level reference model and directed literal checks.
module tb_st_packet_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    sopv = '0;
  logic [N-1:0]    eopv = '0;
  logic            out_ready = 1'b1;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_sop;
  logic            out_eop;
  logic [CW-1:0]   out_channel;
  logic            busy;
  logic            sop_err;

  st_packet_channel_arbiter #(
    .NUM_IN (N), .DATA_W (DW), .CHANNEL_W (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (sopv),
    .in_endofpacket    (eopv),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_channel       (out_channel),
    .busy              (busy),
    .sop_err           (sop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    int         ch;
  } obeat_t;

  beat_t  q[N][$];
  obeat_t olog[$];
  bit     rdy_q[$];
  int     p_valid = 100;
  int     rdy_mode = 0;
  int     compared = 0;
  int     mismatched = 0;
  int     cyc = 0;
  int     errcnt = 0;
  int     t_in = -1;
  int     t_out = -1;
  int     busy_at_eop = -1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester drivers: present queue heads, pop on handshake
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && !reset && q[i].size() > 0) void'(q[i].pop_front());
        if (q[i].size() > 0 && int'($urandom_range(99)) < p_valid) begin
          in_valid[i]         = 1'b1;
          in_data[i*DW +: DW] = q[i][0].d;
          sopv[i]             = q[i][0].s;
          eopv[i]             = q[i][0].e;
        end else begin
          in_valid[i]         = 1'b0;
          in_data[i*DW +: DW] = 8'($urandom);
          sopv[i]             = 1'($urandom);
          eopv[i]             = 1'($urandom);
        end
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(99) < 60);
        default: out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      endcase
    end
  end

  // Reference model: whole-packet ownership, rotating priority
  bit         m_busy = 0;
  int         m_g = 0;
  int         m_last = N - 1;
  bit         m_first = 0;
  bit         ov = 0;
  logic [7:0] od = '0;
  bit         os = 0;
  bit         oe = 0;
  int         och = 0;
  bit         oerr = 0;
  bit         m_le;
  bit         m_acc;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_g = 0; m_last = N - 1; m_first = 0;
      ov = 0; od = '0; os = 0; oe = 0; och = 0; oerr = 0;
    end else begin
      m_le = out_ready || !ov;
      oerr = 0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          if (in_valid[(m_last + k) % N]) begin
            m_g = (m_last + k) % N;
            m_last = m_g;
            m_busy = 1;
            m_first = 1;
            break;
          end
        end
        if (m_le) ov = 0;
      end else begin
        m_acc = in_valid[m_g] && m_le;
        if (m_le) ov = m_acc;
        if (m_acc) begin
          od = in_data[m_g*DW +: DW];
          os = sopv[m_g];
          oe = eopv[m_g];
          och = m_g;
          oerr = m_first ? !os : os;
          m_first = 0;
          if (oe) m_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er;
    if (cyc > 0) begin
      er = '0;
      if (m_busy && (out_ready || !ov)) er[m_g] = 1'b1;
      check("out_valid", 64'(out_valid), 64'(ov));
      check("out_data", 64'(out_data), 64'(od));
      check("out_sop", 64'(out_sop), 64'(os));
      check("out_eop", 64'(out_eop), 64'(oe));
      check("out_channel", 64'(out_channel), 64'(och));
      check("busy", 64'(busy), 64'(m_busy));
      check("in_ready", 64'(in_ready), 64'(er));
      check("sop_err", 64'(sop_err), 64'(oerr));
    end
  end

  // Output log and event capture for the directed checks
  always @(negedge clk) begin
    obeat_t ob;
    if (!reset && out_valid && out_ready) begin
      ob.d = out_data; ob.s = out_sop; ob.e = out_eop;
      ob.ch = int'(out_channel);
      olog.push_back(ob);
    end
    if (!reset && sop_err) errcnt++;
    if (t_in < 0 && in_valid[0]) t_in = cyc;
    if (t_out < 0 && out_valid) t_out = cyc;
    if (busy_at_eop < 0 && out_valid && out_eop) busy_at_eop = int'(busy);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d,
                      input logic s, input logic e);
    beat_t b;
    b.d = d; b.s = s; b.e = e;
    q[r].push_back(b);
  endtask

  task automatic clear_qs();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_qs();
    rdy_q.delete();
    repeat (2) step();
    reset = 1'b0;
    step();
    olog.delete();
    errcnt = 0; t_in = -1; t_out = -1; busy_at_eop = -1;
  endtask

  task automatic drain(input string name, input int budget);
    int quiet;
    bit empty;
    quiet = 0;
    for (int c = 0; c < budget && quiet < 3; c++) begin
      step();
      empty = 1;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) empty = 0;
      if (empty && !out_valid && !busy && in_valid == '0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tot;
    int bad;
    int n;
    logic [7:0] exp3[3];
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;

    // 3-beat packet from requester 0
    do_reset();
    check("reset_last_pick_r0", 64'(m_last), 64'(N - 1));
    push(0, 8'h11, 1, 0); push(0, 8'h22, 0, 0); push(0, 8'h33, 0, 1);
    drain("t1", 50);
    check("t1_count", 64'(olog.size()), 64'd3);
    if (olog.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        check("t1_data", 64'(olog[i].d), 64'(exp3[i]));
        check("t1_chan", 64'(olog[i].ch), 64'd0);
        check("t1_sop", 64'(olog[i].s), 64'(i == 0));
        check("t1_eop", 64'(olog[i].e), 64'(i == 2));
      end
    check("t1_latency", 64'(t_out - t_in), 64'd2);
    check("t1_busy_after_eop", 64'(busy_at_eop), 64'd0);

    // All four requesters with two 2-beat packets each
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++) begin
        push(r, 8'(r * 16 + p * 2), 1, 0);
        push(r, 8'(r * 16 + p * 2 + 1), 0, 1);
      end
    drain("t2", 200);
    check("t2_count", 64'(olog.size()), 64'd16);
    n = 0; bad = 0;
    for (int i = 0; i < olog.size(); i++) begin
      if (olog[i].s) begin
        check("t2_grant_order", 64'(olog[i].ch), 64'(n % N));
        n++;
      end else if (i > 0 && olog[i].ch != olog[i-1].ch) bad++;
    end
    check("t2_interleave", 64'(bad), 64'd0);

    // out_ready stall pattern during a 4-beat packet from requester 2
    do_reset();
    rdy_mode = 2;
    rdy_q = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    for (int i = 0; i < 4; i++) push(2, 8'h41 + 8'(i), i == 0, i == 3);
    drain("t3", 80);
    rdy_mode = 0;
    check("t3_count", 64'(olog.size()), 64'd4);
    if (olog.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        check("t3_data", 64'(olog[i].d), 64'(8'h41 + 8'(i)));
        check("t3_chan", 64'(olog[i].ch), 64'd2);
      end

    // Single-beat packet from 1 while 3 waits
    do_reset();
    push(3, 8'h31, 1, 0); push(3, 8'h32, 0, 1);
    push(1, 8'hA5, 1, 1);
    drain("t4", 50);
    check("t4_count", 64'(olog.size()), 64'd3);
    if (olog.size() >= 2) begin
      check("t4_data", 64'(olog[0].d), 64'hA5);
      check("t4_chan", 64'(olog[0].ch), 64'd1);
      check("t4_sopeop", 64'({olog[0].s, olog[0].e}), 64'b11);
      check("t4_next", 64'(olog[1].ch), 64'd3);
    end

    // Missing sop on the first beat
    do_reset();
    push(0, 8'h50, 0, 0); push(0, 8'h51, 0, 1);
    drain("t5a", 50);
    check("t5_err_pulses", 64'(errcnt), 64'd1);
    if (olog.size() >= 1) check("t5_fwd", 64'(olog[0].d), 64'h50);

    // Reset mid-packet, then requester 0 wins again
    for (int i = 0; i < 6; i++) push(0, 8'h60 + 8'(i), i == 0, i == 5);
    push(2, 8'h70, 1, 0); push(2, 8'h71, 0, 1);
    olog.delete();
    for (int c = 0; c < 40 && olog.size() < 2; c++) step();
    check("t5_midpkt_reached", 64'(olog.size() >= 2), 64'd1);
    reset = 1'b1;
    clear_qs();
    step();
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    olog.delete();
    push(2, 8'h72, 1, 1);
    push(0, 8'h62, 1, 1);
    drain("t5b", 50);
    if (olog.size() >= 1) check("t5_rst_winner", 64'(olog[0].ch), 64'd0);
    else check("t5_rst_out", 64'd0, 64'd1);

    // Randomized traffic with valid gaps and backpressure
    do_reset();
    p_valid = 70;
    rdy_mode = 1;
    tot = 0;
    for (int k = 0; k < 60; k++) begin
      int r;
      int len;
      r = int'($urandom_range(N - 1));
      len = int'($urandom_range(1, 4));
      for (int b = 0; b < len; b++) begin
        push(r, 8'($urandom), (b == 0) ^ ($urandom_range(9) == 0), b == len - 1);
        tot++;
      end
    end
    drain("rand", 5000);
    check("rand_beats", 64'(olog.size()), 64'(tot));
    p_valid = 100;
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
